wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Registered write-back stage of the MIPS pipeline; it generalises the two-input write-back multiplexor.
- Captures the MEM/WB payload and selects one of four write-back sources.
- Extracts and extends sub-word load data (byte/half/word, signed/unsigned).
- Drives the register-file write port and the WB forwarding path one cycle later, with pipeline stall and flush control.

Parameters:
NB_DATA  32  data path width; must be 32 for sub-word load extraction
NB_REG_ADDR  5  register-file address width
NB_SEL  2  write-back source selector width; fixed at 2, four sources

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_stall  input  1  hold all stage registers
i_flush  input  1  squash the stage on the next edge
i_valid  input  1  incoming instruction valid
i_data_alu  input  NB_DATA  ALU result
i_data_mem  input  NB_DATA  raw aligned data-memory word
i_pc_link  input  NB_DATA  return address for JAL/JALR
i_imm_upper  input  NB_DATA  pre-shifted LUI immediate
i_wb_sel  input  NB_SEL  source select: 0=mem, 1=alu, 2=link, 3=imm
i_mem_size  input  2  00=byte, 01=half, 10=word, 11=word
i_mem_unsigned  input  1  1 = zero-extend, 0 = sign-extend
i_byte_off  input  2  byte offset of the load address
i_reg_write  input  1  instruction writes the register file
i_reg_addr  input  NB_REG_ADDR  destination register
o_wb_data  output  NB_DATA  write-back data
o_wb_addr  output  NB_REG_ADDR  write-back register address
o_wb_en  output  1  register-file write enable
o_valid  output  1  stage holds a valid instruction

Behaviour:
- Reset: i_rst_n low clears o_wb_data, o_wb_addr, o_wb_en and o_valid to 0 immediately, independent of the clock. Release is synchronous to the next edge; there is no capture on the release edge itself unless i_rst_n is high at that edge.
- Latency: exactly 1 cycle from the input sample to the registered outputs. All outputs come straight from registers; there is no combinational input-to-output path.
- Priority at each rising edge: i_flush > i_stall > capture.
- Flush: all outputs go to 0 (o_valid=0, o_wb_en=0). Flush wins over a simultaneous stall.
- Stall, no flush: every output register holds its value. Input changes are ignored.
- Capture, neither asserted:
  - o_valid <= i_valid.
  - o_wb_addr <= i_reg_addr.
  - o_wb_en <= i_valid & i_reg_write & (i_reg_addr != 0). A write to r0 is never issued.
  - o_wb_data <= selected source, per the rules below.
- Source select:
  - 0: load-extracted memory data.
  - 1: i_data_alu.
  - 2: i_pc_link.
  - 3: i_imm_upper.
- Load extraction (source 0 only), little-endian byte lanes: lane k = i_data_mem[8k+7:8k].
  - Byte: the lane is chosen by i_byte_off, then extended to 32 bits (zero if unsigned, sign from bit 7 otherwise).
  - Half: i_byte_off[1] picks the upper/lower 16 bits; i_byte_off[0] is ignored (alignment is a MEM-stage fault). The half is extended from bit 15 per i_mem_unsigned.
  - Word (size 10 or 11): i_data_mem passes unchanged; i_byte_off and i_mem_unsigned are ignored.
- When i_valid=0, the payload is still captured into o_wb_data/o_wb_addr, but o_wb_en=0 and o_valid=0.
- A stall held over many cycles keeps o_wb_en asserted if it was asserted. The register file tolerates rewriting the same value.

Test Plan:
- Reset mid-operation: with o_wb_en=1 and o_wb_data=0xDEADBEEF, drive i_rst_n low between edges -> all outputs 0 immediately. First capture occurs on the first edge with i_rst_n high.
- Source select: i_data_alu=0x11, i_pc_link=0x400008, i_imm_upper=0x12340000; sweep i_wb_sel 1,2,3 with valid, write, addr=5 -> o_wb_data follows each value one cycle later, o_wb_en=1, o_wb_addr=5.
- Load extraction: i_data_mem=0x80FF7F01, sel=0.
  - Byte signed, off 0..3 -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
  - Byte unsigned, off 3 -> 0x00000080.
  - Half signed, off 2 -> 0xFFFF80FF.
  - Half unsigned, off 0 -> 0x00007F01.
  - Word -> 0x80FF7F01.
- r0 / invalid suppression: i_reg_addr=0 with valid and write -> o_wb_en=0. addr=7 with i_valid=0 -> o_wb_en=0, o_valid=0.
- Stall hold: capture ALU 0xAA to r3, then assert i_stall for 3 cycles while inputs change to 0xBB/r9 -> outputs stay 0xAA/r3/en=1. On release, 0xBB/r9 appears one cycle later.
- Flush vs stall: assert i_stall and i_flush together while holding a valid write -> next edge gives o_valid=0, o_wb_en=0, o_wb_data=0.

Source files
------------

// File: rtl/wb_stage_if.sv
// MEM/WB payload and write-back port bundle for wb_stage.
// master drives the stage inputs, slave is the write-back stage itself.
interface wb_stage_if #(
   parameter int NB_DATA     = 32,
   parameter int NB_REG_ADDR = 5,
   parameter int NB_SEL      = 2
);
   logic                   i_stall;
   logic                   i_flush;
   logic                   i_valid;
   logic [NB_DATA-1:0]     i_data_alu;
   logic [NB_DATA-1:0]     i_data_mem;
   logic [NB_DATA-1:0]     i_pc_link;
   logic [NB_DATA-1:0]     i_imm_upper;
   logic [NB_SEL-1:0]      i_wb_sel;
   logic [1:0]             i_mem_size;
   logic                   i_mem_unsigned;
   logic [1:0]             i_byte_off;
   logic                   i_reg_write;
   logic [NB_REG_ADDR-1:0] i_reg_addr;
   logic [NB_DATA-1:0]     o_wb_data;
   logic [NB_REG_ADDR-1:0] o_wb_addr;
   logic                   o_wb_en;
   logic                   o_valid;

   modport master (
      output i_stall, i_flush, i_valid, i_data_alu, i_data_mem, i_pc_link,
             i_imm_upper, i_wb_sel, i_mem_size, i_mem_unsigned, i_byte_off,
             i_reg_write, i_reg_addr,
      input  o_wb_data, o_wb_addr, o_wb_en, o_valid
   );

   modport slave (
      input  i_stall, i_flush, i_valid, i_data_alu, i_data_mem, i_pc_link,
             i_imm_upper, i_wb_sel, i_mem_size, i_mem_unsigned, i_byte_off,
             i_reg_write, i_reg_addr,
      output o_wb_data, o_wb_addr, o_wb_en, o_valid
   );
endinterface

// File: rtl/wb_stage.sv
// Registered MIPS write-back stage: 4-way source select with sub-word load extraction.
// One cycle latency, all outputs registered; flush beats stall beats capture.
module wb_stage #(
   parameter int NB_DATA     = 32,
   parameter int NB_REG_ADDR = 5,
   parameter int NB_SEL      = 2
) (
   input  logic     i_clk,
   input  logic     i_rst_n,
   wb_stage_if.slave bus
);

   localparam logic [NB_SEL-1:0] SEL_MEM  = 2'd0;
   localparam logic [NB_SEL-1:0] SEL_ALU  = 2'd1;
   localparam logic [NB_SEL-1:0] SEL_LINK = 2'd2;
   localparam logic [NB_SEL-1:0] SEL_IMM  = 2'd3;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;

   logic [7:0]             byte_lane;
   logic [15:0]            half_lane;
   logic [NB_DATA-1:0]     load_data;
   logic [NB_DATA-1:0]     src_data;
   logic                   wr_en_next;

   logic [NB_DATA-1:0]     wb_data_q;
   logic [NB_REG_ADDR-1:0] wb_addr_q;
   logic                   wb_en_q;
   logic                   valid_q;

   // Little-endian lanes: lane k sits at bits [8k+7:8k].
   always_comb begin
      byte_lane = bus.i_data_mem[7:0];
      case (bus.i_byte_off)
         2'd0: byte_lane = bus.i_data_mem[7:0];
         2'd1: byte_lane = bus.i_data_mem[15:8];
         2'd2: byte_lane = bus.i_data_mem[23:16];
         2'd3: byte_lane = bus.i_data_mem[31:24];
         default: byte_lane = bus.i_data_mem[7:0];
      endcase
   end

   // Low offset bit is ignored for halves; misalignment traps in MEM.
   assign half_lane = bus.i_byte_off[1] ? bus.i_data_mem[31:16] : bus.i_data_mem[15:0];

   always_comb begin
      load_data = bus.i_data_mem;
      case (bus.i_mem_size)
         SIZE_BYTE: load_data = {{24{byte_lane[7] & ~bus.i_mem_unsigned}}, byte_lane};
         SIZE_HALF: load_data = {{16{half_lane[15] & ~bus.i_mem_unsigned}}, half_lane};
         default:   load_data = bus.i_data_mem;
      endcase
   end

   always_comb begin
      src_data = load_data;
      case (bus.i_wb_sel)
         SEL_MEM:  src_data = load_data;
         SEL_ALU:  src_data = bus.i_data_alu;
         SEL_LINK: src_data = bus.i_pc_link;
         SEL_IMM:  src_data = bus.i_imm_upper;
         default:  src_data = load_data;
      endcase
   end

   // r0 is hardwired to zero, so a write to it is never issued.
   assign wr_en_next = bus.i_valid & bus.i_reg_write & (bus.i_reg_addr != '0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wb_data_q <= '0;
         wb_addr_q <= '0;
         wb_en_q   <= 1'b0;
         valid_q   <= 1'b0;
      end else if (bus.i_flush) begin
         wb_data_q <= '0;
         wb_addr_q <= '0;
         wb_en_q   <= 1'b0;
         valid_q   <= 1'b0;
      end else if (!bus.i_stall) begin
         wb_data_q <= src_data;
         wb_addr_q <= bus.i_reg_addr;
         wb_en_q   <= wr_en_next;
         valid_q   <= bus.i_valid;
      end
   end

   assign bus.o_wb_data = wb_data_q;
   assign bus.o_wb_addr = wb_addr_q;
   assign bus.o_wb_en   = wb_en_q;
   assign bus.o_valid   = valid_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed plan cases plus randomized traffic
// checked against a behavioural model of the write-back rules.
module tb_wb_stage;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  addr;
      logic        en;
      logic        valid;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   exp_t cur;
   exp_t sb_q[$];

   wb_stage_if #(.NB_DATA(32), .NB_REG_ADDR(5), .NB_SEL(2)) bus ();

   wb_stage #(.NB_DATA(32), .NB_REG_ADDR(5), .NB_SEL(2)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   task automatic chk_all(input string tag, input exp_t e);
      chk({tag, ".data"},  bus.o_wb_data, e.data);
      chk({tag, ".addr"},  {27'd0, bus.o_wb_addr}, {27'd0, e.addr});
      chk({tag, ".en"},    {31'd0, bus.o_wb_en}, {31'd0, e.en});
      chk({tag, ".valid"}, {31'd0, bus.o_valid}, {31'd0, e.valid});
   endtask

   // Sub-word extraction by shift/mask arithmetic.
   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                            input logic u, input logic [1:0] off);
      logic [31:0] v;
      if (sz >= 2'd2) return w;
      if (sz == 2'd0) begin
         v = (w >> (8 * off)) & 32'h0000_00FF;
         if (!u && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end else begin
         v = (w >> (16 * off[1])) & 32'h0000_FFFF;
         if (!u && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      return v;
   endfunction

   task automatic step(input logic fl, input logic st, input logic v, input logic w,
                       input logic [4:0] addr, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] link, input logic [31:0] imm,
                       input logic [1:0] sz, input logic u, input logic [1:0] off);
      exp_t nx;
      @(negedge clk);
      bus.i_flush = fl;        bus.i_stall = st;       bus.i_valid = v;
      bus.i_reg_write = w;     bus.i_reg_addr = addr;  bus.i_wb_sel = sel;
      bus.i_data_alu = alu;    bus.i_data_mem = mem;   bus.i_pc_link = link;
      bus.i_imm_upper = imm;   bus.i_mem_size = sz;    bus.i_mem_unsigned = u;
      bus.i_byte_off = off;
      nx = cur;
      if (fl) nx = '0;
      else if (!st) begin
         nx.valid = v;
         nx.addr  = addr;
         nx.en    = v && w && (addr != 0);
         case (sel)
            2'd0: nx.data = ref_load(mem, sz, u, off);
            2'd1: nx.data = alu;
            2'd2: nx.data = link;
            default: nx.data = imm;
         endcase
      end
      cur = nx;
      sb_q.push_back(nx);
   endtask

   task automatic cap_alu(input logic [31:0] alu, input logic [4:0] addr, input logic st);
      step(1'b0, st, 1'b1, 1'b1, addr, 2'd1, alu, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, 2'd0);
   endtask

   task automatic ld(input logic [1:0] sz, input logic u, input logic [1:0] off);
      step(1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 2'd0, 32'h55, 32'h80FF7F01, 32'h0, 32'h0, sz, u, off);
   endtask

   // Monitor: one registered output per clock, compared against the queue head.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk_all("sb", e);
         end
      end
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cur      = '0;
      rst_n    = 1'b1;
      bus.i_flush = 0; bus.i_stall = 0; bus.i_valid = 0; bus.i_reg_write = 0;
      bus.i_reg_addr = 0; bus.i_wb_sel = 0; bus.i_data_alu = 0; bus.i_data_mem = 0;
      bus.i_pc_link = 0; bus.i_imm_upper = 0; bus.i_mem_size = 0;
      bus.i_mem_unsigned = 0; bus.i_byte_off = 0;
      #2 rst_n = 1'b0;
      #1 chk_all("reset", '0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Source select sweep
      for (int s = 1; s <= 3; s++)
         step(1'b0, 1'b0, 1'b1, 1'b1, 5'd5, s[1:0], 32'h11, 32'h0, 32'h0040_0008,
              32'h1234_0000, 2'd2, 1'b0, 2'd0);

      // Load extraction
      for (int o = 0; o < 4; o++) ld(2'd0, 1'b0, o[1:0]);
      ld(2'd0, 1'b1, 2'd3);
      ld(2'd1, 1'b0, 2'd2);
      ld(2'd1, 1'b1, 2'd0);
      ld(2'd2, 1'b0, 2'd1);
      ld(2'd3, 1'b1, 2'd3);

      // r0 and invalid suppression
      cap_alu(32'h77, 5'd0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 2'd1, 32'h99, 0, 0, 0, 2'd2, 1'b0, 2'd0);

      // Stall hold, then release
      cap_alu(32'hAA, 5'd3, 1'b0);
      repeat (3) cap_alu(32'hBB, 5'd9, 1'b1);
      cap_alu(32'hBB, 5'd9, 1'b0);

      // Flush beats stall
      step(1'b1, 1'b1, 1'b1, 1'b1, 5'd12, 2'd1, 32'hCC, 0, 0, 0, 2'd2, 1'b0, 2'd0);

      // Asynchronous reset mid-operation, inputs still presenting a valid write
      cap_alu(32'hDEADBEEF, 5'd4, 1'b0);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1 chk_all("async_rst", '0);
      @(posedge clk);
      #1 chk_all("rst_hold", '0);
      cur = '0;
      @(negedge clk) rst_n = 1'b1;
      cap_alu(32'h1357, 5'd8, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] r;
         r = $urandom;
         step($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0, r[0], r[1],
              r[6:2], r[8:7], $urandom, $urandom, $urandom, $urandom,
              r[10:9], r[11], r[13:12]);
      end

      @(negedge clk);
      repeat (2) @(posedge clk);
      #2;
      if (sb_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
